// File: rtl/vdp_timing_gen.sv
// vdp_timing_gen: runtime-programmable raster timing generator for the VDP.
// The register interface writes a shadow timing set. The active set drives the
// raster counters and only changes at a frame boundary, or at once while the
// generator is disabled, so a mode switch never produces a torn frame.
// CTRL and IRQ_LINE write straight into live registers.
module vdp_timing_gen #(
  parameter int HW     = 12,
  parameter int VW     = 11,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic          i_clk_vid,
  input  logic          i_rst,
  input  logic          i_cfg_we,
  input  logic [3:0]    i_cfg_addr,
  input  logic [15:0]   i_cfg_wdata,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic          o_hblank,
  output logic          o_vblank,
  output logic [HW-1:0] o_x,
  output logic [VW-1:0] o_y,
  output logic [15:0]   o_frame_cnt,
  output logic          o_sof,
  output logic          o_irq_vblank,
  output logic          o_irq_line,
  output logic          o_commit_pending
);

  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [VW-1:0] V_ONE = VW'(1);

  localparam logic [HW-1:0] D_HVIS  = HW'(H_VIS);
  localparam logic [HW-1:0] D_HFP   = HW'(H_FP);
  localparam logic [HW-1:0] D_HSYNC = HW'(H_SYNC);
  localparam logic [HW-1:0] D_HBP   = HW'(H_BP);
  localparam logic [VW-1:0] D_VVIS  = VW'(V_VIS);
  localparam logic [VW-1:0] D_VFP   = VW'(V_FP);
  localparam logic [VW-1:0] D_VSYNC = VW'(V_SYNC);
  localparam logic [VW-1:0] D_VBP   = VW'(V_BP);

  // Field order inside each set: 0 visible, 1 front porch, 2 sync, 3 back porch.
  logic [HW-1:0] r_shH  [4];
  logic [VW-1:0] r_shV  [4];
  logic [HW-1:0] r_actH [4];
  logic [VW-1:0] r_actV [4];

  logic          r_commit_pending;
  logic          r_enable;
  logic          r_hs_pol;
  logic          r_vs_pol;
  logic [VW-1:0] r_irq_line;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [15:0]   r_frame_cnt;

  logic          w_wr_h;
  logic          w_wr_v;
  logic          w_wr_ctrl;
  logic          w_wr_irq;
  logic          w_wr_commit;
  logic [HW-1:0] w_wdata_h;
  logic [VW-1:0] w_wdata_v;
  logic          w_enable;
  logic          w_hs_pol;
  logic          w_vs_pol;
  logic [HW-1:0] w_htot;
  logic [VW-1:0] w_vtot;
  logic [HW-1:0] w_hs_start;
  logic [HW-1:0] w_hs_end;
  logic [VW-1:0] w_vs_start;
  logic [VW-1:0] w_vs_end;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_frame_end;
  logic          w_apply;
  logic          w_hvis;
  logic          w_vvis;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_h0;
  logic          w_unused;

  assign w_wr_h      = i_cfg_we && (i_cfg_addr[3:2] == 2'b00);
  assign w_wr_v      = i_cfg_we && (i_cfg_addr[3:2] == 2'b01);
  assign w_wr_ctrl   = i_cfg_we && (i_cfg_addr == 4'd8);
  assign w_wr_irq    = i_cfg_we && (i_cfg_addr == 4'd9);
  assign w_wr_commit = i_cfg_we && (i_cfg_addr == 4'd15);

  // Visible and sync fields sit at even addresses; a zero there becomes 1.
  assign w_wdata_h = ((i_cfg_wdata[HW-1:0] == '0) && !i_cfg_addr[0]) ? H_ONE : i_cfg_wdata[HW-1:0];
  assign w_wdata_v = ((i_cfg_wdata[VW-1:0] == '0) && !i_cfg_addr[0]) ? V_ONE : i_cfg_wdata[VW-1:0];
  assign w_unused  = ^i_cfg_wdata[15:HW];

  // A CTRL write in this cycle acts on this cycle's output, not one cycle later.
  assign w_enable = w_wr_ctrl ? i_cfg_wdata[0] : r_enable;
  assign w_hs_pol = w_wr_ctrl ? i_cfg_wdata[1] : r_hs_pol;
  assign w_vs_pol = w_wr_ctrl ? i_cfg_wdata[2] : r_vs_pol;

  assign w_htot     = r_actH[0] + r_actH[1] + r_actH[2] + r_actH[3];
  assign w_vtot     = r_actV[0] + r_actV[1] + r_actV[2] + r_actV[3];
  assign w_hs_start = r_actH[0] + r_actH[1];
  assign w_hs_end   = w_hs_start + r_actH[2];
  assign w_vs_start = r_actV[0] + r_actV[1];
  assign w_vs_end   = w_vs_start + r_actV[2];

  assign w_h_last    = (r_hcnt == (w_htot - H_ONE));
  assign w_v_last    = (r_vcnt == (w_vtot - V_ONE));
  assign w_frame_end = w_h_last && w_v_last;
  assign w_apply     = r_commit_pending && (!w_enable || w_frame_end);

  assign w_hvis   = (r_hcnt < r_actH[0]);
  assign w_vvis   = (r_vcnt < r_actV[0]);
  assign w_hs_act = (r_hcnt >= w_hs_start) && (r_hcnt < w_hs_end);
  assign w_vs_act = (r_vcnt >= w_vs_start) && (r_vcnt < w_vs_end);
  assign w_h0     = (r_hcnt == '0);

  // Shadow writes, commit request and the atomic shadow-to-active transfer.
  // A new commit request wins over the clear, so a request that arrives on the
  // frame-end cycle waits for the following boundary.
  always_ff @(posedge i_clk_vid) begin
    if (i_rst) begin
      r_shH            <= '{D_HVIS, D_HFP, D_HSYNC, D_HBP};
      r_shV            <= '{D_VVIS, D_VFP, D_VSYNC, D_VBP};
      r_actH           <= '{D_HVIS, D_HFP, D_HSYNC, D_HBP};
      r_actV           <= '{D_VVIS, D_VFP, D_VSYNC, D_VBP};
      r_commit_pending <= 1'b0;
    end else begin
      if (w_apply) begin
        r_actH           <= r_shH;
        r_actV           <= r_shV;
        r_commit_pending <= 1'b0;
      end
      if (w_wr_h) r_shH[i_cfg_addr[1:0]] <= w_wdata_h;
      if (w_wr_v) r_shV[i_cfg_addr[1:0]] <= w_wdata_v;
      if (w_wr_commit) r_commit_pending <= 1'b1;
    end
  end

  // Live control registers that bypass the shadow set.
  always_ff @(posedge i_clk_vid) begin
    if (i_rst) begin
      r_enable   <= 1'b1;
      r_hs_pol   <= 1'b0;
      r_vs_pol   <= 1'b0;
      r_irq_line <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= i_cfg_wdata[0];
        r_hs_pol <= i_cfg_wdata[1];
        r_vs_pol <= i_cfg_wdata[2];
      end
      if (w_wr_irq) r_irq_line <= i_cfg_wdata[VW-1:0];
    end
  end

  // Raster counters. They are held at the origin while the generator is disabled.
  always_ff @(posedge i_clk_vid) begin
    if (i_rst || !w_enable) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : (r_vcnt + V_ONE);
    end else begin
      r_hcnt <= r_hcnt + H_ONE;
    end
  end

  // Completed-frame counter; advances on the frame-end cycle and wraps.
  always_ff @(posedge i_clk_vid) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
    end else if (w_enable && w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Registered outputs, decoded from the counter state one cycle earlier.
  always_ff @(posedge i_clk_vid) begin
    if (i_rst) begin
      o_hs         <= 1'b1;
      o_vs         <= 1'b1;
      o_de         <= 1'b0;
      o_hblank     <= 1'b1;
      o_vblank     <= 1'b1;
      o_x          <= '0;
      o_y          <= '0;
      o_frame_cnt  <= '0;
      o_sof        <= 1'b0;
      o_irq_vblank <= 1'b0;
      o_irq_line   <= 1'b0;
    end else begin
      o_hs         <= (w_enable && w_hs_act) ? w_hs_pol : ~w_hs_pol;
      o_vs         <= (w_enable && w_vs_act) ? w_vs_pol : ~w_vs_pol;
      o_de         <= w_enable && w_hvis && w_vvis;
      o_hblank     <= !(w_enable && w_hvis);
      o_vblank     <= !(w_enable && w_vvis);
      o_x          <= (w_enable && w_hvis && w_vvis) ? r_hcnt : '0;
      o_y          <= (w_enable && w_vvis) ? r_vcnt : '0;
      o_frame_cnt  <= r_frame_cnt;
      o_sof        <= w_enable && w_h0 && (r_vcnt == '0);
      o_irq_vblank <= w_enable && w_h0 && (r_vcnt == r_actV[0]);
      o_irq_line   <= w_enable && w_h0 && (r_vcnt == r_irq_line) && (r_irq_line < w_vtot);
    end
  end

  assign o_commit_pending = r_commit_pending;

endmodule

// File: tb/tb_vdp_timing_gen.sv
// tb_vdp_timing_gen: scoreboard bench for the raster timing generator.
// The stimulus process pushes hand-computed expectations into a queue. The
// monitor pops them on the falling edge that follows and compares them with
// the DUT outputs or with its own pulse counters.
module tb_vdp_timing_gen;

  logic        clkVid = 1'b0;
  logic        rst;
  logic        cfgWe;
  logic [3:0]  cfgAddr;
  logic [15:0] cfgWdata;
  logic        hs, vs, de, hblank, vblank;
  logic [11:0] x;
  logic [10:0] y;
  logic [15:0] frameCnt;
  logic        sof, irqVblank, irqLine, commitPending;

  typedef enum int {
    S_HS, S_VS, S_DE, S_HBLANK, S_VBLANK, S_X, S_Y, S_FRAME,
    S_SOF, S_IRQV, S_IRQL, S_PEND, S_NSOF, S_NIRQV, S_NIRQL, S_CLR
  } sel_e;

  typedef struct {
    string name;
    sel_e  sel;
    int    expv;
  } item_t;

  item_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  int    nSof   = 0;
  int    nIrqV  = 0;
  int    nIrqL  = 0;
  int    pos    = 0;

  vdp_timing_gen dut (
    .i_clk_vid        (clkVid),
    .i_rst            (rst),
    .i_cfg_we         (cfgWe),
    .i_cfg_addr       (cfgAddr),
    .i_cfg_wdata      (cfgWdata),
    .o_hs             (hs),
    .o_vs             (vs),
    .o_de             (de),
    .o_hblank         (hblank),
    .o_vblank         (vblank),
    .o_x              (x),
    .o_y              (y),
    .o_frame_cnt      (frameCnt),
    .o_sof            (sof),
    .o_irq_vblank     (irqVblank),
    .o_irq_line       (irqLine),
    .o_commit_pending (commitPending)
  );

  // Pixel clock.
  always #5 clkVid = ~clkVid;

  // Global time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, required completion", checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int actualOf(input sel_e s);
    case (s)
      S_HS:     return int'(hs);
      S_VS:     return int'(vs);
      S_DE:     return int'(de);
      S_HBLANK: return int'(hblank);
      S_VBLANK: return int'(vblank);
      S_X:      return int'(x);
      S_Y:      return int'(y);
      S_FRAME:  return int'(frameCnt);
      S_SOF:    return int'(sof);
      S_IRQV:   return int'(irqVblank);
      S_IRQL:   return int'(irqLine);
      S_PEND:   return int'(commitPending);
      S_NSOF:   return nSof;
      S_NIRQV:  return nIrqV;
      S_NIRQL:  return nIrqL;
      default:  return -1;
    endcase
  endfunction

  // Monitor: count pulses of this cycle, then drain and compare queued expectations.
  always @(negedge clkVid) begin
    item_t it;
    int    act;
    if (sof) nSof++;
    if (irqVblank) nIrqV++;
    if (irqLine) nIrqL++;
    while (expQ.size() != 0) begin
      it = expQ.pop_front();
      if (it.sel == S_CLR) begin
        nSof  = 0;
        nIrqV = 0;
        nIrqL = 0;
      end else begin
        act = actualOf(it.sel);
        checks++;
        if (act != it.expv) begin
          errors++;
          $display("[TB] FAIL %s: got %0d, expected %0d", it.name, act, it.expv);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkVid);
      #1;
      pos++;
    end
  endtask

  task automatic goTo(input int target);
    tick(target - pos);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [15:0] d);
    cfgWe    = 1'b1;
    cfgAddr  = a;
    cfgWdata = d;
    tick(1);
    cfgWe    = 1'b0;
  endtask

  task automatic checkOutput(input string nm, input sel_e s, input int e);
    item_t it;
    it.name = nm;
    it.sel  = s;
    it.expv = e;
    expQ.push_back(it);
  endtask

  task automatic clearCounts();
    checkOutput("clear", S_CLR, 0);
  endtask

  task automatic waitSof(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (sof) return;
    end
    checkOutput("waitSof timeout", S_SOF, 1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " hs"}, S_HS, 1);
    checkOutput({tag, " vs"}, S_VS, 1);
    checkOutput({tag, " de"}, S_DE, 0);
    checkOutput({tag, " hblank"}, S_HBLANK, 1);
    checkOutput({tag, " vblank"}, S_VBLANK, 1);
    checkOutput({tag, " x"}, S_X, 0);
    checkOutput({tag, " y"}, S_Y, 0);
    checkOutput({tag, " frame_cnt"}, S_FRAME, 0);
    checkOutput({tag, " sof"}, S_SOF, 0);
    checkOutput({tag, " commit_pending"}, S_PEND, 0);
  endtask

  initial begin
    cfgWe = 1'b0; cfgAddr = '0; cfgWdata = '0; rst = 1'b1;
    tick(3);
    checkResetState("reset");

    checks++;
    if (hs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL direct reset hs: got %b, expected 1", hs);
    end
    checks++;
    if (vs !== 1'b1) begin
      errors++;
      $display("[TB] FAIL direct reset vs: got %b, expected 1", vs);
    end
    checks++;
    if (de !== 1'b0) begin
      errors++;
      $display("[TB] FAIL direct reset de: got %b, expected 0", de);
    end
    checks++;
    if (frameCnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL direct reset frame_cnt: got %0d, expected 0", frameCnt);
    end
    checks++;
    if (commitPending !== 1'b0) begin
      errors++;
      $display("[TB] FAIL direct reset commit_pending: got %b, expected 0", commitPending);
    end

    // Default 800x525 timing from the first counted cycle.
    rst = 1'b0;
    tick(1); pos = 0;
    checkOutput("dflt sof at origin", S_SOF, 1);
    checkOutput("dflt de at origin", S_DE, 1);
    checkOutput("dflt x at origin", S_X, 0);
    checkOutput("dflt y at origin", S_Y, 0);
    checkOutput("dflt hblank at origin", S_HBLANK, 0);
    checkOutput("dflt vblank at origin", S_VBLANK, 0);
    checkOutput("dflt hs at origin", S_HS, 1);
    checkOutput("dflt irq_line line0", S_IRQL, 1);
    checkOutput("dflt irq_vblank origin", S_IRQV, 0);
    goTo(639); checkOutput("dflt de last col", S_DE, 1); checkOutput("dflt x last col", S_X, 639);
    goTo(640); checkOutput("dflt de after vis", S_DE, 0); checkOutput("dflt hblank after vis", S_HBLANK, 1);
    checkOutput("dflt x in hblank", S_X, 0);
    goTo(655); checkOutput("dflt hs before sync", S_HS, 1);
    goTo(656); checkOutput("dflt hs sync start", S_HS, 0);
    goTo(751); checkOutput("dflt hs sync last", S_HS, 0);
    goTo(752); checkOutput("dflt hs after sync", S_HS, 1);
    goTo(800); checkOutput("dflt line1 x", S_X, 0); checkOutput("dflt line1 y", S_Y, 1);
    checkOutput("dflt line1 de", S_DE, 1); checkOutput("dflt line1 sof", S_SOF, 0);
    checkOutput("dflt line1 irq_line", S_IRQL, 0);

    // Shadow timing A: H 8/2/2/2 (14), V 4/1/1/1 (7), then commit.
    applyStimulus(4'd0, 16'd8); applyStimulus(4'd1, 16'd2);
    applyStimulus(4'd2, 16'd2); applyStimulus(4'd3, 16'd2);
    applyStimulus(4'd4, 16'd4); applyStimulus(4'd5, 16'd1);
    applyStimulus(4'd6, 16'd1); applyStimulus(4'd7, 16'd1);
    applyStimulus(4'd15, 16'd0);
    checkOutput("commit_pending set", S_PEND, 1);

    // Disable mid-frame: idle outputs and the pending commit applies at once.
    applyStimulus(4'd8, 16'd0);
    checkOutput("dis hs", S_HS, 1); checkOutput("dis vs", S_VS, 1);
    checkOutput("dis de", S_DE, 0); checkOutput("dis hblank", S_HBLANK, 1);
    checkOutput("dis vblank", S_VBLANK, 1); checkOutput("dis x", S_X, 0);
    checkOutput("dis y", S_Y, 0); checkOutput("dis sof", S_SOF, 0);
    checkOutput("dis commit applied", S_PEND, 0);
    clearCounts();
    tick(20);
    checkOutput("dis no sof", S_NSOF, 0); checkOutput("dis no irq_vblank", S_NIRQV, 0);
    checkOutput("dis no irq_line", S_NIRQL, 0); checkOutput("dis de held", S_DE, 0);
    checkOutput("dis x held", S_X, 0);

    // Re-enable: count from (0,0) with timing A, 98-clock frames.
    applyStimulus(4'd8, 16'd1); pos = 0;
    checkOutput("en sof", S_SOF, 1); checkOutput("en de", S_DE, 1);
    checkOutput("en x", S_X, 0); checkOutput("en y", S_Y, 0);
    checkOutput("en pending", S_PEND, 0); checkOutput("en frame_cnt", S_FRAME, 0);
    goTo(7);  checkOutput("A de col7", S_DE, 1); checkOutput("A x col7", S_X, 7);
    goTo(8);  checkOutput("A de col8", S_DE, 0); checkOutput("A hblank col8", S_HBLANK, 1);
    checkOutput("A x col8", S_X, 0);
    goTo(9);  checkOutput("A hs col9", S_HS, 1);
    goTo(10); checkOutput("A hs col10", S_HS, 0);
    goTo(11); checkOutput("A hs col11", S_HS, 0);
    goTo(12); checkOutput("A hs col12", S_HS, 1);
    goTo(14); checkOutput("A line1 x", S_X, 0); checkOutput("A line1 y", S_Y, 1);
    checkOutput("A line1 de", S_DE, 1); checkOutput("A line1 hblank", S_HBLANK, 0);
    goTo(56); checkOutput("A irq_vblank", S_IRQV, 1); checkOutput("A vblank line4", S_VBLANK, 1);
    checkOutput("A y in vblank", S_Y, 0); checkOutput("A de line4", S_DE, 0);
    goTo(57); checkOutput("A irq_vblank one cycle", S_IRQV, 0);
    goTo(69); checkOutput("A vs line4", S_VS, 1);
    goTo(70); checkOutput("A vs line5 start", S_VS, 0);
    goTo(83); checkOutput("A vs line5 end", S_VS, 0);
    goTo(84); checkOutput("A vs line6", S_VS, 1);
    goTo(97); checkOutput("A sof last pixel", S_SOF, 0); checkOutput("A frame_cnt before", S_FRAME, 0);
    goTo(98); checkOutput("A sof period 98", S_SOF, 1); checkOutput("A frame_cnt after", S_FRAME, 1);
    checkOutput("A x frame2", S_X, 0); checkOutput("A y frame2", S_Y, 0);

    // IRQ_LINE = 2: one pulse per frame at (0,2).
    applyStimulus(4'd9, 16'd2);
    waitSof(200); pos = 0;
    clearCounts();
    goTo(28); checkOutput("irq_line at y2", S_IRQL, 1); checkOutput("irq_line y", S_Y, 2);
    checkOutput("irq_line x", S_X, 0); checkOutput("irq_line de", S_DE, 1);
    goTo(29); checkOutput("irq_line one cycle", S_IRQL, 0);
    goTo(294); checkOutput("irq_line count 3 frames", S_NIRQL, 3);
    checkOutput("sof count 3 frames", S_NSOF, 3); checkOutput("irq_vblank count 3 frames", S_NIRQV, 3);

    // IRQ_LINE = 6 is the last line and fires; 7 equals V_TOT and never fires.
    applyStimulus(4'd9, 16'd6);
    waitSof(200); pos = 0;
    clearCounts();
    goTo(84); checkOutput("irq_line last line", S_IRQL, 1); checkOutput("irq_line last y", S_Y, 0);
    goTo(98); checkOutput("irq_line last count", S_NIRQL, 1);
    applyStimulus(4'd9, 16'd7);
    waitSof(200); pos = 0;
    clearCounts();
    goTo(196); checkOutput("irq_line at vtot silent", S_NIRQL, 0); checkOutput("sof count 2 frames", S_NSOF, 2);

    // hs polarity change mid-line.
    pos = 0;
    goTo(9); checkOutput("pol hs before", S_HS, 1);
    applyStimulus(4'd8, 16'd3);
    checkOutput("pol hs active high", S_HS, 1);
    goTo(12); checkOutput("pol hs idle low", S_HS, 0);
    goTo(13); checkOutput("pol hs idle low 13", S_HS, 0); checkOutput("pol vs unchanged", S_VS, 1);
    applyStimulus(4'd8, 16'd1);
    checkOutput("pol hs restored", S_HS, 1);

    // Mid-frame commit of timing B: H 6/1/0->1/1 (9), V 3/1/1/1 (6).
    waitSof(200); pos = 0;
    applyStimulus(4'd0, 16'd6); applyStimulus(4'd1, 16'd1);
    applyStimulus(4'd2, 16'd0); applyStimulus(4'd3, 16'd1);
    applyStimulus(4'd4, 16'd3); applyStimulus(4'd5, 16'd1);
    applyStimulus(4'd6, 16'd1); applyStimulus(4'd7, 16'd1);
    applyStimulus(4'd15, 16'd0);
    checkOutput("B pending", S_PEND, 1);
    goTo(14); checkOutput("B old line1 y", S_Y, 1); checkOutput("B old line1 x", S_X, 0);
    goTo(96); checkOutput("B pending before end", S_PEND, 1);
    goTo(97); checkOutput("B pending cleared", S_PEND, 0); checkOutput("B sof not yet", S_SOF, 0);
    goTo(98); pos = 0;
    checkOutput("B sof", S_SOF, 1); checkOutput("B x0", S_X, 0);
    checkOutput("B y0", S_Y, 0); checkOutput("B de0", S_DE, 1);
    goTo(5);  checkOutput("B de col5", S_DE, 1); checkOutput("B x col5", S_X, 5);
    goTo(6);  checkOutput("B de col6", S_DE, 0); checkOutput("B hblank col6", S_HBLANK, 1);
    goTo(7);  checkOutput("B hs clamped sync", S_HS, 0);
    goTo(8);  checkOutput("B hs after sync", S_HS, 1);
    goTo(9);  checkOutput("B line1 x", S_X, 0); checkOutput("B line1 y", S_Y, 1);
    goTo(27); checkOutput("B irq_vblank", S_IRQV, 1); checkOutput("B vblank", S_VBLANK, 1);
    goTo(53); checkOutput("B sof not yet", S_SOF, 0);
    goTo(54); checkOutput("B sof period 54", S_SOF, 1);

    // Commit written on the frame-end cycle: one more B frame, then A.
    pos = 0;
    applyStimulus(4'd0, 16'd8); applyStimulus(4'd1, 16'd2);
    applyStimulus(4'd2, 16'd2); applyStimulus(4'd3, 16'd2);
    applyStimulus(4'd4, 16'd4); applyStimulus(4'd5, 16'd1);
    applyStimulus(4'd6, 16'd1); applyStimulus(4'd7, 16'd1);
    goTo(52);
    applyStimulus(4'd15, 16'd0);
    checkOutput("fe pending kept", S_PEND, 1); checkOutput("fe sof", S_SOF, 0);
    goTo(54);  checkOutput("fe sof B again", S_SOF, 1); checkOutput("fe pending frame", S_PEND, 1);
    goTo(60);  checkOutput("fe still B de", S_DE, 0); checkOutput("fe still B hblank", S_HBLANK, 1);
    goTo(106); checkOutput("fe pending before end", S_PEND, 1);
    goTo(107); checkOutput("fe pending cleared", S_PEND, 0);
    goTo(108); checkOutput("fe sof A", S_SOF, 1);
    goTo(114); checkOutput("fe A de col6", S_DE, 1); checkOutput("fe A x col6", S_X, 6);
    goTo(116); checkOutput("fe A de col8", S_DE, 0);
    goTo(205); checkOutput("fe A sof not yet", S_SOF, 0);
    goTo(206); checkOutput("fe A sof period 98", S_SOF, 1);

    // Reset mid-frame with a pending commit.
    goTo(210);
    applyStimulus(4'd15, 16'd0);
    checkOutput("rst pre pending", S_PEND, 1);
    goTo(220);
    rst = 1'b1;
    tick(1);
    checkResetState("midrst");
    rst = 1'b0;
    tick(1); pos = 0;
    checkOutput("post rst sof", S_SOF, 1); checkOutput("post rst de", S_DE, 1);
    checkOutput("post rst pending", S_PEND, 0);
    goTo(639); checkOutput("post rst de col639", S_DE, 1); checkOutput("post rst x col639", S_X, 639);
    goTo(640); checkOutput("post rst de col640", S_DE, 0); checkOutput("post rst hblank", S_HBLANK, 1);

    tick(3);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL expectation queue not drained: %0d left", expQ.size());
    end
    if (checks < 12) begin
      errors++;
      $display("[TB] FAIL too few checks executed: %0d", checks);
    end
    if (errors == 0)
      $display("[TB] PASS: %0d checks, 0 errors", checks);
    else
      $display("[TB] FAIL: %0d checks, %0d errors", checks, errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
